// File: rtl/gpsdo_pwm_pkg.sv
// ----------------------------------------------------------------------------
// gpsdo_pwm_pkg
//   Shared definitions for the GPSDO OCXO tuning PWM duty path: duty word
//   width, PWM period, default duty limits, the sequencer FSM encoding and a
//   clamp helper that reports whether the request was pulled into range.
// ----------------------------------------------------------------------------
package gpsdo_pwm_pkg;

    localparam int DUTY_W        = 17;
    localparam int PWM_PERIOD    = 65535;
    localparam int DUTY_MIN_DEF  = 1;
    // The duty must stay strictly below the period so the output never sits
    // at a constant level.
    localparam int DUTY_MAX_DEF  = PWM_PERIOD - 1;
    localparam int MAX_STEP_DEF  = 256;
    localparam int DUTY_INIT_DEF = 32768;

    typedef logic signed [DUTY_W-1:0] duty_t;
    // One guard bit so target - current never overflows for clamped values.
    typedef logic signed [DUTY_W:0]   duty_diff_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_e;

    typedef struct packed {
        duty_t value;
        logic  clamped;
    } clamp_res_t;

    function automatic clamp_res_t clamp_duty(duty_t req, duty_t lo, duty_t hi);
        clamp_res_t res;
        res.value   = req;
        res.clamped = 1'b0;
        if (req < lo) begin
            res.value   = lo;
            res.clamped = 1'b1;
        end else if (req > hi) begin
            res.value   = hi;
            res.clamped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// ----------------------------------------------------------------------------
// pwm_duty_sequencer_if
//   Bundles the request, arbitration and status signals of the PWM duty
//   sequencer.
//   master : the requester side (loop filter, host, PWM period counter)
//   slave  : the duty sequencer
//   Signals:
//     PERIOD_START           1-cycle pulse when the PWM period counter wraps
//     HOST_Hold              1: host owns the duty, 0: loop filter owns it
//     LOOP_Valid/Duty/Ready  loop filter request handshake
//     HOST_Valid/Duty/Ready  host request handshake
//     PWM_Duty               applied duty word
//     UPD_Strobe             1-cycle pulse when PWM_Duty changes
//     SLEW_Active            duty is still moving toward the target
//     CLAMP_Flag             most recent accepted request was clamped
// ----------------------------------------------------------------------------
interface pwm_duty_sequencer_if;
    import gpsdo_pwm_pkg::*;

    logic  PERIOD_START;
    logic  HOST_Hold;
    logic  LOOP_Valid;
    duty_t LOOP_Duty;
    logic  LOOP_Ready;
    logic  HOST_Valid;
    duty_t HOST_Duty;
    logic  HOST_Ready;
    duty_t PWM_Duty;
    logic  UPD_Strobe;
    logic  SLEW_Active;
    logic  CLAMP_Flag;

    modport master (
        output PERIOD_START, HOST_Hold,
        output LOOP_Valid, LOOP_Duty,
        output HOST_Valid, HOST_Duty,
        input  LOOP_Ready, HOST_Ready,
        input  PWM_Duty, UPD_Strobe, SLEW_Active, CLAMP_Flag
    );

    modport slave (
        input  PERIOD_START, HOST_Hold,
        input  LOOP_Valid, LOOP_Duty,
        input  HOST_Valid, HOST_Duty,
        output LOOP_Ready, HOST_Ready,
        output PWM_Duty, UPD_Strobe, SLEW_Active, CLAMP_Flag
    );

endinterface

// File: rtl/duty_step_calc.sv
// ----------------------------------------------------------------------------
// duty_step_calc
//   Combinational single-period slew step: moves cur toward target by at most
//   MAX_STEP and never past the target.
//   Ports:
//     cur     in   current applied duty
//     target  in   duty being slewed toward
//     nxt     out  duty to apply for the next period
//     done    out  nxt equals target
// ----------------------------------------------------------------------------
module duty_step_calc
    import gpsdo_pwm_pkg::*;
#(
    parameter int MAX_STEP = MAX_STEP_DEF
) (
    input  duty_t cur,
    input  duty_t target,
    output duty_t nxt,
    output logic  done
);

    localparam duty_diff_t STEP = duty_diff_t'(MAX_STEP);

    duty_diff_t cur_w;
    duty_diff_t tgt_w;
    duty_diff_t diff;
    duty_diff_t nxt_w;

    always_comb begin
        cur_w = {cur[DUTY_W-1], cur};
        tgt_w = {target[DUTY_W-1], target};
        diff  = tgt_w - cur_w;
        if (diff > STEP) begin
            nxt_w = cur_w + STEP;
        end else if (diff < -STEP) begin
            nxt_w = cur_w - STEP;
        end else begin
            // Within one step: land exactly on the target, no overshoot.
            nxt_w = tgt_w;
        end
        nxt  = nxt_w[DUTY_W-1:0];
        done = (nxt_w == tgt_w);
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// ----------------------------------------------------------------------------
// pwm_duty_sequencer
//   Owns the OCXO tuning PWM duty word. Arbitrates between the loop filter and
//   the host (HOST_Hold), clamps accepted requests to [DUTY_MIN, DUTY_MAX] and
//   slews the applied duty toward the target by at most MAX_STEP, changing it
//   only on PWM period boundaries.
//   Ports:
//     CLK_SYS   in   system clock
//     CLK_RST   in   asynchronous active-low reset
//     bus       slave side of pwm_duty_sequencer_if (requests and status)
// ----------------------------------------------------------------------------
module pwm_duty_sequencer
    import gpsdo_pwm_pkg::*;
#(
    parameter int DUTY_MIN  = DUTY_MIN_DEF,
    parameter int DUTY_MAX  = DUTY_MAX_DEF,
    parameter int MAX_STEP  = MAX_STEP_DEF,
    parameter int DUTY_INIT = DUTY_INIT_DEF
) (
    input  logic                 CLK_SYS,
    input  logic                 CLK_RST,
    pwm_duty_sequencer_if.slave  bus
);

    localparam duty_t DUTY_MIN_C  = duty_t'(DUTY_MIN);
    localparam duty_t DUTY_MAX_C  = duty_t'(DUTY_MAX);
    localparam duty_t DUTY_INIT_C = duty_t'(DUTY_INIT);

    seq_state_e state_q, state_d;
    duty_t      duty_q, duty_d;
    duty_t      target_q, target_d;
    logic       upd_q, upd_d;
    logic       clamp_q, clamp_d;

    logic       loop_ready;
    logic       host_ready;
    logic       accept;
    duty_t      owner_req;
    clamp_res_t req_clamp;
    duty_t      step_nxt;
    logic       step_done;

    // Ownership is purely combinational; the non-owner is simply never ready,
    // so its requests are dropped rather than queued.
    assign loop_ready = ~bus.HOST_Hold;
    assign host_ready =  bus.HOST_Hold;
    assign accept     = (bus.LOOP_Valid & loop_ready) | (bus.HOST_Valid & host_ready);
    assign owner_req  = bus.HOST_Hold ? bus.HOST_Duty : bus.LOOP_Duty;
    assign req_clamp  = clamp_duty(owner_req, DUTY_MIN_C, DUTY_MAX_C);

    // The step always works from the registered (old) target, so an accept on
    // the same cycle as PERIOD_START only takes effect from the next boundary.
    duty_step_calc #(
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .cur    (duty_q),
        .target (target_q),
        .nxt    (step_nxt),
        .done   (step_done)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        upd_d    = 1'b0;
        clamp_d  = clamp_q;

        if (accept) begin
            target_d = req_clamp.value;
            clamp_d  = req_clamp.clamped;
        end

        case (state_q)
            ST_IDLE: begin
                // PERIOD_START is ignored here; arm once a new target is latched.
                if (target_q != duty_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.PERIOD_START) begin
                    duty_d = step_nxt;
                    upd_d  = (step_nxt != duty_q);
                end
                if (accept) begin
                    // A retarget decides against the duty that will be applied,
                    // including a retarget onto the current duty (no step needed).
                    state_d = (target_d != duty_d) ? ST_ARMED : ST_IDLE;
                end else if (bus.PERIOD_START ? step_done : (target_q == duty_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            state_q  <= ST_IDLE;
            duty_q   <= DUTY_INIT_C;
            target_q <= DUTY_INIT_C;
            upd_q    <= 1'b0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            upd_q    <= upd_d;
            clamp_q  <= clamp_d;
        end
    end

    assign bus.LOOP_Ready  = loop_ready;
    assign bus.HOST_Ready  = host_ready;
    assign bus.PWM_Duty    = duty_q;
    assign bus.UPD_Strobe  = upd_q;
    assign bus.SLEW_Active = (state_q == ST_ARMED);
    assign bus.CLAMP_Flag  = clamp_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pwm_duty_sequencer
//   Self-checking bench for pwm_duty_sequencer: a cycle table for the main
//   directed scenarios, hand-written multi-cycle corner sequences, and a
//   randomized run against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_pwm_duty_sequencer;
    import gpsdo_pwm_pkg::*;

    localparam int MS   = 256;
    localparam int INIT = 32768;
    localparam int DMIN = 1;
    localparam int DMAX = 65534;

    logic CLK_SYS = 1'b0;
    logic CLK_RST;

    always #5 CLK_SYS = ~CLK_SYS;

    pwm_duty_sequencer_if u_if ();

    pwm_duty_sequencer #(
        .DUTY_MIN  (DMIN),
        .DUTY_MAX  (DMAX),
        .MAX_STEP  (MS),
        .DUTY_INIT (INIT)
    ) dut (
        .CLK_SYS (CLK_SYS),
        .CLK_RST (CLK_RST),
        .bus     (u_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic hold;
        logic lv;
        int   ld;
        logic hv;
        int   hd;
        logic ps;
        int   e_duty;
        logic e_upd;
        logic e_flag;
        logic e_slew;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic hold, input logic lv, input int ld,
                                input logic hv, input int hd, input logic ps,
                                input int e_duty, input logic e_upd,
                                input logic e_flag, input logic e_slew);
        vec_t v;
        v.hold = hold; v.lv = lv; v.ld = ld; v.hv = hv; v.hd = hd; v.ps = ps;
        v.e_duty = e_duty; v.e_upd = e_upd; v.e_flag = e_flag; v.e_slew = e_slew;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic hold, input logic lv, input int ld,
                         input logic hv, input int hd, input logic ps);
        u_if.HOST_Hold    = hold;
        u_if.LOOP_Valid   = lv;
        u_if.LOOP_Duty    = duty_t'(ld);
        u_if.HOST_Valid   = hv;
        u_if.HOST_Duty    = duty_t'(hd);
        u_if.PERIOD_START = ps;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Advance one clock; leaves the bench 1 time unit after the active edge.
    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        CLK_RST = 1'b0;
        #2;
        @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        tick();
    endtask

    task automatic check_outs(input string tag, input int duty, input logic upd,
                              input logic flag, input logic slew);
        check({tag, " duty"}, u_if.PWM_Duty, duty);
        check({tag, " upd"},  u_if.UPD_Strobe, upd);
        check({tag, " flag"}, u_if.CLAMP_Flag, flag);
        check({tag, " slew"}, u_if.SLEW_Active, slew);
    endtask

    // Random request: sometimes far, sometimes near or equal to the current duty,
    // sometimes outside the clamp range; always representable in DUTY_W bits.
    function automatic int rand_req(input int near);
        int r;
        case ($urandom_range(0, 3))
            0:       r = near + int'($urandom_range(0, 600)) - 300;
            1:       r = near;
            default: r = int'($urandom_range(0, 68535)) - 3000;
        endcase
        if (r > 65535) r = 65535;
        return r;
    endfunction

    initial begin
        int m_duty, m_target, d, req, g;
        logic m_flag, m_upd, ps, hold, lv, hv, acc;
        int ld, hd;

        // ---------------- reset state ----------------
        idle_inputs();
        CLK_RST = 1'b0;
        #12;
        check_outs("reset", INIT, 1'b0, 1'b0, 1'b0);
        check("reset loop_ready", u_if.LOOP_Ready, 1);
        check("reset host_ready", u_if.HOST_Ready, 0);
        @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        tick();

        // ---------------- directed table ----------------
        // 4 boundaries with no request: nothing moves.
        for (int i = 0; i < 4; i++) begin
            add(0, 0, 0, 0, 0, 1, 32768, 0, 0, 0);
            add(0, 0, 0, 0, 0, 0, 32768, 0, 0, 0);
        end
        // Loop 33000: one partial step; then 34000 in four steps.
        add(0, 1, 33000, 0, 0, 0, 32768, 0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 32768, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 33000, 1, 0, 0);
        add(0, 0, 0,     0, 0, 0, 33000, 0, 0, 0);
        add(0, 1, 34000, 0, 0, 0, 33000, 0, 0, 0);
        add(0, 0, 0,     0, 0, 0, 33000, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 33256, 1, 0, 1);
        add(0, 0, 0,     0, 0, 0, 33256, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 33512, 1, 0, 1);
        add(0, 0, 0,     0, 0, 0, 33512, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 33768, 1, 0, 1);
        add(0, 0, 0,     0, 0, 0, 33768, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 34000, 1, 0, 0);
        add(0, 0, 0,     0, 0, 0, 34000, 0, 0, 0);
        add(0, 0, 0,     0, 0, 1, 34000, 0, 0, 0);
        // Clamping high, low, then an in-range request clears the flag.
        add(0, 1, 65535, 0, 0, 0, 34000, 0, 1, 0);
        add(0, 0, 0,     0, 0, 0, 34000, 0, 1, 1);
        add(0, 0, 0,     0, 0, 1, 34256, 1, 1, 1);
        add(0, 1, -5,    0, 0, 0, 34256, 0, 1, 1);
        add(0, 0, 0,     0, 0, 1, 34000, 1, 1, 1);
        add(0, 1, 500,   0, 0, 0, 34000, 0, 0, 1);
        add(0, 0, 0,     0, 0, 1, 33744, 1, 0, 1);
        // Host hold: loop ignored, target kept, host request retargets.
        add(1, 1, 40000, 0, 0,     0, 33744, 0, 0, 1);
        add(1, 1, 40000, 0, 0,     1, 33488, 1, 0, 1);
        add(1, 0, 0,     1, 30000, 0, 33488, 0, 0, 1);
        add(1, 0, 0,     0, 0,     1, 33232, 1, 0, 1);
        add(1, 0, 0,     0, 0,     0, 33232, 0, 0, 1);
        add(1, 0, 0,     0, 0,     1, 32976, 1, 0, 1);
        add(0, 0, 0,     1, 20000, 0, 32976, 0, 0, 1);
        add(0, 0, 0,     0, 0,     1, 32720, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].hold, vecs[i].lv, vecs[i].ld, vecs[i].hv, vecs[i].hd, vecs[i].ps);
            #1;
            check($sformatf("vec%0d loop_ready", i), u_if.LOOP_Ready, !vecs[i].hold);
            check($sformatf("vec%0d host_ready", i), u_if.HOST_Ready, vecs[i].hold);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_duty, vecs[i].e_upd,
                       vecs[i].e_flag, vecs[i].e_slew);
        end

        // ---------------- accept on the same cycle as PERIOD_START ----------------
        apply_reset();
        drive(0, 1, 33000, 0, 0, 0); tick();
        idle_inputs();               tick();
        drive(0, 1, 40000, 0, 0, 1); tick();
        check_outs("simul step", 33000, 1'b1, 1'b0, 1'b1);
        idle_inputs();               tick();
        check_outs("simul gap", 33000, 1'b0, 1'b0, 1'b1);
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("simul next", 33256, 1'b1, 1'b0, 1'b1);

        // ---------------- accept equal to duty while ARMED ----------------
        apply_reset();
        drive(0, 1, 34000, 0, 0, 0); tick();
        idle_inputs();               tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("eq step", 33024, 1'b1, 1'b0, 1'b1);
        drive(0, 1, 33024, 0, 0, 0); tick();
        check_outs("eq accept", 33024, 1'b0, 1'b0, 1'b0);
        idle_inputs();               tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("eq boundary", 33024, 1'b0, 1'b0, 1'b0);

        // ---------------- reset asserted mid-slew ----------------
        apply_reset();
        drive(0, 1, 34000, 0, 0, 0); tick();
        idle_inputs();               tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        idle_inputs();               tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("pre-rst", 33280, 1'b1, 1'b0, 1'b1);
        idle_inputs();
        #1;
        CLK_RST = 1'b0;
        #1;
        check_outs("async rst", INIT, 1'b0, 1'b0, 1'b0);
        @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("post-rst boundary", INIT, 1'b0, 1'b0, 1'b0);
        idle_inputs();               tick();
        drive(0, 0, 0, 0, 0, 1);     tick();
        check_outs("post-rst boundary2", INIT, 1'b0, 1'b0, 1'b0);

        // ---------------- randomized run vs reference model ----------------
        // Requests never land on the cycle right before a boundary, so the
        // model can treat "duty differs from target" as "a step is due".
        apply_reset();
        m_duty   = INIT;
        m_target = INIT;
        m_flag   = 1'b0;
        for (int p = 0; p < 300; p++) begin
            g = int'($urandom_range(3, 8));
            for (int k = 0; k < g; k++) begin
                ps   = (k == 0);
                hold = ($urandom_range(0, 3) == 0);
                lv   = (k != g - 1) && ($urandom_range(0, 2) == 0);
                hv   = (k != g - 1) && ($urandom_range(0, 2) == 0);
                ld   = rand_req(m_duty);
                hd   = rand_req(m_duty);
                drive(hold, lv, ld, hv, hd, ps);
                #1;
                check("rnd loop_ready", u_if.LOOP_Ready, !hold);
                check("rnd host_ready", u_if.HOST_Ready, hold);
                if (ps) check("rnd slew", u_if.SLEW_Active, m_target != m_duty);
                tick();

                m_upd = 1'b0;
                if (ps && m_duty != m_target) begin
                    d = m_target - m_duty;
                    if (d > MS)       m_duty = m_duty + MS;
                    else if (d < -MS) m_duty = m_duty - MS;
                    else              m_duty = m_target;
                    m_upd = 1'b1;
                end
                acc = hold ? hv : lv;
                if (acc) begin
                    req      = hold ? hd : ld;
                    m_flag   = (req < DMIN) || (req > DMAX);
                    m_target = (req < DMIN) ? DMIN : ((req > DMAX) ? DMAX : req);
                end
                check("rnd duty", u_if.PWM_Duty, m_duty);
                check("rnd upd",  u_if.UPD_Strobe, m_upd);
                check("rnd flag", u_if.CLAMP_Flag, m_flag);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
